// File: rtl/viola_pkg.sv
// Shared decode definitions: op codes, RV32I major opcodes, decoded-instruction
// record and the funct3 -> ALU op mapping shared by OP and OP-IMM.
package viola_pkg;

  localparam int OP_W = 5;
  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_LUI   = 5'd0;
  localparam op_t OP_AUIPC = 5'd1;
  localparam op_t OP_JAL   = 5'd2;
  localparam op_t OP_JALR  = 5'd3;
  localparam op_t OP_BEQ   = 5'd4;
  localparam op_t OP_BNE   = 5'd5;
  localparam op_t OP_BLT   = 5'd6;
  localparam op_t OP_BGE   = 5'd7;
  localparam op_t OP_BLTU  = 5'd8;
  localparam op_t OP_BGEU  = 5'd9;
  localparam op_t OP_LB    = 5'd10;
  localparam op_t OP_LH    = 5'd11;
  localparam op_t OP_LW    = 5'd12;
  localparam op_t OP_LBU   = 5'd13;
  localparam op_t OP_LHU   = 5'd14;
  localparam op_t OP_SB    = 5'd15;
  localparam op_t OP_SH    = 5'd16;
  localparam op_t OP_SW    = 5'd17;
  localparam op_t OP_ADD   = 5'd18;
  localparam op_t OP_SUB   = 5'd19;
  localparam op_t OP_SLL   = 5'd20;
  localparam op_t OP_SLT   = 5'd21;
  localparam op_t OP_SLTU  = 5'd22;
  localparam op_t OP_XOR   = 5'd23;
  localparam op_t OP_SRL   = 5'd24;
  localparam op_t OP_SRA   = 5'd25;
  localparam op_t OP_OR    = 5'd26;
  localparam op_t OP_AND   = 5'd27;
  localparam op_t OP_NONE  = 5'b11111;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;

  typedef struct packed {
    op_t         op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        has_imm;
  } dec_inst_t;

  localparam dec_inst_t DEC_BUBBLE = '{op: OP_NONE, rs1: 5'd0, rs2: 5'd0, rd: 5'd0,
                                       imm: 32'd0, has_imm: 1'b0};

  // Base (funct7 = 0) ALU op selected by funct3; OP and OP-IMM share it.
  function automatic op_t alu_op(input logic [2:0] funct3);
    case (funct3)
      3'd0:    return OP_ADD;
      3'd1:    return OP_SLL;
      3'd2:    return OP_SLT;
      3'd3:    return OP_SLTU;
      3'd4:    return OP_XOR;
      3'd5:    return OP_SRL;
      3'd6:    return OP_OR;
      default: return OP_AND;
    endcase
  endfunction

endpackage

// File: rtl/inst_decode_if.sv
// Fetch-side handshake plus issue-side decoded bus of the decode stage.
// master = fetch/queue environment, slave = the decoder.
interface inst_decode_if;
  import viola_pkg::*;

  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_ready;
  logic        flush;
  logic        iq_full;
  op_t         op;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] imm;
  logic        has_imm;
  logic        illegal;

  modport master (
    output inst, inst_valid, flush, iq_full,
    input  inst_ready, op, rs1, rs2, rd, imm, has_imm, illegal
  );

  modport slave (
    input  inst, inst_valid, flush, iq_full,
    output inst_ready, op, rs1, rs2, rd, imm, has_imm, illegal
  );

endinterface

// File: rtl/rv32i_decoder.sv
// Purely combinational RV32I word decoder: classifies the word, picks the op
// code and instruction format, then assembles operands/immediate per format.
module rv32i_decoder
  import viola_pkg::*;
(
  input  logic [31:0] inst_i,
  output dec_inst_t   dec_o,
  output logic        is_illegal_o
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  op_t         op_sel;
  fmt_e        fmt;
  logic        shift_imm;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];

  assign imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
  assign imm_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign imm_b = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_u = {inst_i[31:12], 12'd0};
  assign imm_j = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

  // Classify the word: op code, format, shift-immediate flag, legality.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves one unassigned and infers a latch.
    op_sel       = OP_NONE;
    fmt          = FMT_R;
    shift_imm    = 1'b0;
    is_illegal_o = 1'b0;
    case (opcode)
      OPC_LUI:   begin op_sel = OP_LUI;   fmt = FMT_U; end
      OPC_AUIPC: begin op_sel = OP_AUIPC; fmt = FMT_U; end
      OPC_JAL:   begin op_sel = OP_JAL;   fmt = FMT_J; end
      OPC_JALR: begin
        op_sel       = OP_JALR;
        fmt          = FMT_I;
        is_illegal_o = (funct3 != 3'd0);
      end
      OPC_BRANCH: begin
        fmt = FMT_B;
        case (funct3)
          3'd0:    op_sel = OP_BEQ;
          3'd1:    op_sel = OP_BNE;
          3'd4:    op_sel = OP_BLT;
          3'd5:    op_sel = OP_BGE;
          3'd6:    op_sel = OP_BLTU;
          3'd7:    op_sel = OP_BGEU;
          default: is_illegal_o = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        fmt = FMT_I;
        case (funct3)
          3'd0:    op_sel = OP_LB;
          3'd1:    op_sel = OP_LH;
          3'd2:    op_sel = OP_LW;
          3'd4:    op_sel = OP_LBU;
          3'd5:    op_sel = OP_LHU;
          default: is_illegal_o = 1'b1;
        endcase
      end
      OPC_STORE: begin
        fmt = FMT_S;
        case (funct3)
          3'd0:    op_sel = OP_SB;
          3'd1:    op_sel = OP_SH;
          3'd2:    op_sel = OP_SW;
          default: is_illegal_o = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        fmt    = FMT_I;
        op_sel = alu_op(funct3);
        case (funct3)
          // An ADDI carrying the SUB funct7 pattern is rejected as "SUBI".
          3'd0: is_illegal_o = (funct7 == F7_ALT);
          3'd1: begin
            shift_imm    = 1'b1;
            is_illegal_o = (funct7 != F7_BASE);
          end
          3'd5: begin
            shift_imm = 1'b1;
            if (funct7 == F7_ALT)       op_sel = OP_SRA;
            else if (funct7 != F7_BASE) is_illegal_o = 1'b1;
          end
          default: ;
        endcase
      end
      OPC_OP: begin
        fmt = FMT_R;
        if (funct7 == F7_BASE) begin
          op_sel = alu_op(funct3);
        end else if (funct7 == F7_ALT && funct3 == 3'd0) begin
          op_sel = OP_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'd5) begin
          op_sel = OP_SRA;
        end else begin
          is_illegal_o = 1'b1;
        end
      end
      default: is_illegal_o = 1'b1;
    endcase
  end

  // Assemble the decoded record; unused register fields stay zero.
  always_comb begin
    dec_o    = DEC_BUBBLE;
    dec_o.op = is_illegal_o ? OP_NONE : op_sel;
    case (fmt)
      FMT_R: begin
        dec_o.rd  = inst_i[11:7];
        dec_o.rs1 = inst_i[19:15];
        dec_o.rs2 = inst_i[24:20];
      end
      FMT_I: begin
        dec_o.rd      = inst_i[11:7];
        dec_o.rs1     = inst_i[19:15];
        dec_o.imm     = shift_imm ? {27'd0, inst_i[24:20]} : imm_i;
        dec_o.has_imm = 1'b1;
      end
      FMT_S: begin
        dec_o.rs1     = inst_i[19:15];
        dec_o.rs2     = inst_i[24:20];
        dec_o.imm     = imm_s;
        dec_o.has_imm = 1'b1;
      end
      FMT_B: begin
        dec_o.rs1     = inst_i[19:15];
        dec_o.rs2     = inst_i[24:20];
        dec_o.imm     = imm_b;
        dec_o.has_imm = 1'b1;
      end
      FMT_U: begin
        dec_o.rd      = inst_i[11:7];
        dec_o.imm     = imm_u;
        dec_o.has_imm = 1'b1;
      end
      default: begin
        dec_o.rd      = inst_i[11:7];
        dec_o.imm     = imm_j;
        dec_o.has_imm = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/inst_decode.sv
// Decode stage: accepts RV32I words from fetch, decodes them, buffers them in a
// small skid FIFO and issues one per cycle onto registered outputs unless the
// instruction queue reports iq_full. Optional feature macro:
// DECODE_ILLEGAL_TRAP_EN -- an accepted illegal word raises a sticky illegal
// flag and halts acceptance until flush or reset.
module inst_decode
  import viola_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  inst_decode_if.slave bus
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  dec_inst_t              dec;
  logic                   dec_illegal;
  dec_inst_t              buf_mem [BUF_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  dec_inst_t              out_q, out_d;
  logic                   halt_q;
  logic                   accept, push, pop;

  rv32i_decoder u_decoder (
    .inst_i       (bus.inst),
    .dec_o        (dec),
    .is_illegal_o (dec_illegal)
  );

  assign bus.inst_ready = rst && (count_q < CNT_W'(BUF_DEPTH)) && !halt_q;
  assign accept         = bus.inst_valid && bus.inst_ready;
  assign push           = accept && !dec_illegal && !bus.flush;
  assign pop            = !bus.iq_full && (count_q != '0) && !bus.flush;

  // Next-state for pointers, occupancy and the issue register.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    out_d    = out_q;
    out_d.op = OP_NONE;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop) begin
        out_d    = buf_mem[rd_ptr_q];
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      out_q    <= DEC_BUBBLE;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      out_q    <= out_d;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; count_q alone decides which entries are meaningful.
    if (push) buf_mem[wr_ptr_q] <= dec;
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic halt_d;

  // Sticky trap: set by an accepted illegal word, cleared only by flush.
  always_comb begin
    halt_d = halt_q;
    if (bus.flush)                  halt_d = 1'b0;
    else if (accept && dec_illegal) halt_d = 1'b1;
  end

  // Trap flag register.
  always_ff @(posedge clk) begin
    if (!rst) halt_q <= 1'b0;
    else      halt_q <= halt_d;
  end
`else
  assign halt_q = 1'b0;
`endif

  assign bus.op      = out_q.op;
  assign bus.rs1     = out_q.rs1;
  assign bus.rs2     = out_q.rs2;
  assign bus.rd      = out_q.rd;
  assign bus.imm     = out_q.imm;
  assign bus.has_imm = out_q.has_imm;
  assign bus.illegal = halt_q;

endmodule

// File: tb/tb_inst_decode.sv
// Self-checking bench for inst_decode: directed scenarios followed by random
// traffic, compared against a queue-based model fed by an instruction
// generator that knows each word's decoded fields by construction.
module tb_inst_decode;
  import viola_pkg::*;

  localparam int DEPTH = 2;
`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    logic [31:0] w;
    bit          legal;
    dec_inst_t   e;
  } stim_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_decode_if bus ();

  inst_decode #(.BUF_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int        checks = 0;
  int        errors = 0;
  dec_inst_t model_q[$];
  dec_inst_t exp_out;
  logic      exp_illegal;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_ready();
    return (model_q.size() < DEPTH) && !exp_illegal;
  endfunction

  task automatic check_outputs();
    check("op",      32'(bus.op),      32'(exp_out.op));
    check("rs1",     32'(bus.rs1),     32'(exp_out.rs1));
    check("rs2",     32'(bus.rs2),     32'(exp_out.rs2));
    check("rd",      32'(bus.rd),      32'(exp_out.rd));
    check("imm",     bus.imm,          exp_out.imm);
    check("has_imm", 32'(bus.has_imm), 32'(exp_out.has_imm));
    check("illegal", 32'(bus.illegal), 32'(exp_illegal));
  endtask

  // One clock: drive inputs, check ready, advance the model, check outputs.
  task automatic cycle(input logic v, input stim_t s, input logic fl, input logic full);
    logic acc;
    bus.inst       = s.w;
    bus.inst_valid = v;
    bus.flush      = fl;
    bus.iq_full    = full;
    #1;
    check("inst_ready", 32'(bus.inst_ready), 32'(model_ready()));
    acc = v && model_ready();
    if (fl) begin
      model_q.delete();
      exp_out.op  = OP_NONE;
      exp_illegal = 1'b0;
    end else begin
      if (!full && model_q.size() > 0) exp_out = model_q.pop_front();
      else exp_out.op = OP_NONE;
      if (acc) begin
        if (s.legal) model_q.push_back(s.e);
        else if (TRAP) exp_illegal = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset(input logic v, input logic [31:0] w);
    rst            = 1'b0;
    bus.inst       = w;
    bus.inst_valid = v;
    bus.flush      = 1'b0;
    bus.iq_full    = 1'b0;
    @(posedge clk);
    #1;
    model_q.delete();
    exp_out     = DEC_BUBBLE;
    exp_illegal = 1'b0;
    check("reset inst_ready", 32'(bus.inst_ready), 32'd0);
    check_outputs();
    rst = 1'b1;
  endtask

  // Builds a random instruction word from chosen fields; the expected decode
  // is exactly those fields.
  function automatic stim_t gen(input bit allow_illegal);
    stim_t       s;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] v;
    int          k, idx;
    logic [2:0]  f3;
    logic [6:0]  f7;
    rd  = 5'($urandom);
    rs1 = 5'($urandom);
    rs2 = 5'($urandom);
    s.legal     = 1'b1;
    s.e         = DEC_BUBBLE;
    s.e.has_imm = 1'b1;
    k = $urandom_range(0, allow_illegal ? 9 : 8);
    case (k)
      0: begin
        idx = $urandom_range(0, 9);
        f7  = (idx == 1 || idx == 7) ? 7'h20 : 7'h00;
        case (idx)
          0: begin f3 = 3'd0; s.e.op = OP_ADD;  end
          1: begin f3 = 3'd0; s.e.op = OP_SUB;  end
          2: begin f3 = 3'd1; s.e.op = OP_SLL;  end
          3: begin f3 = 3'd2; s.e.op = OP_SLT;  end
          4: begin f3 = 3'd3; s.e.op = OP_SLTU; end
          5: begin f3 = 3'd4; s.e.op = OP_XOR;  end
          6: begin f3 = 3'd5; s.e.op = OP_SRL;  end
          7: begin f3 = 3'd5; s.e.op = OP_SRA;  end
          8: begin f3 = 3'd6; s.e.op = OP_OR;   end
          default: begin f3 = 3'd7; s.e.op = OP_AND; end
        endcase
        s.w = {f7, rs2, rs1, f3, rd, 7'b0110011};
        s.e.rd = rd; s.e.rs1 = rs1; s.e.rs2 = rs2; s.e.has_imm = 1'b0;
      end
      1, 3, 8: begin
        v = 32'($urandom_range(0, 4095)) - 32'd2048;
        if (k == 1 && v[11:5] == 7'b0100000) v[5] = 1'b1;
        idx = $urandom_range(0, 5);
        if (k == 1) begin
          case (idx)
            0: begin f3 = 3'd0; s.e.op = OP_ADD;  end
            1: begin f3 = 3'd2; s.e.op = OP_SLT;  end
            2: begin f3 = 3'd3; s.e.op = OP_SLTU; end
            3: begin f3 = 3'd4; s.e.op = OP_XOR;  end
            4: begin f3 = 3'd6; s.e.op = OP_OR;   end
            default: begin f3 = 3'd7; s.e.op = OP_AND; end
          endcase
          s.w = {v[11:0], rs1, f3, rd, 7'b0010011};
        end else if (k == 3) begin
          case (idx)
            0: begin f3 = 3'd0; s.e.op = OP_LB;  end
            1: begin f3 = 3'd1; s.e.op = OP_LH;  end
            2: begin f3 = 3'd2; s.e.op = OP_LW;  end
            3: begin f3 = 3'd4; s.e.op = OP_LBU; end
            default: begin f3 = 3'd5; s.e.op = OP_LHU; end
          endcase
          s.w = {v[11:0], rs1, f3, rd, 7'b0000011};
        end else begin
          s.e.op = OP_JALR;
          s.w = {v[11:0], rs1, 3'd0, rd, 7'b1100111};
        end
        s.e.rd = rd; s.e.rs1 = rs1; s.e.imm = v;
      end
      2: begin
        idx = $urandom_range(0, 2);
        case (idx)
          0: begin f3 = 3'd1; f7 = 7'h00; s.e.op = OP_SLL; end
          1: begin f3 = 3'd5; f7 = 7'h00; s.e.op = OP_SRL; end
          default: begin f3 = 3'd5; f7 = 7'h20; s.e.op = OP_SRA; end
        endcase
        s.w = {f7, rs2, rs1, f3, rd, 7'b0010011};
        s.e.rd = rd; s.e.rs1 = rs1; s.e.imm = {27'd0, rs2};
      end
      4: begin
        v   = 32'($urandom_range(0, 4095)) - 32'd2048;
        idx = $urandom_range(0, 2);
        f3  = 3'(idx);
        s.e.op = (idx == 0) ? OP_SB : (idx == 1) ? OP_SH : OP_SW;
        s.w = {v[11:5], rs2, rs1, f3, v[4:0], 7'b0100011};
        s.e.rs1 = rs1; s.e.rs2 = rs2; s.e.imm = v;
      end
      5: begin
        v   = (32'($urandom_range(0, 4095)) - 32'd2048) * 2;
        idx = $urandom_range(0, 5);
        case (idx)
          0: begin f3 = 3'd0; s.e.op = OP_BEQ;  end
          1: begin f3 = 3'd1; s.e.op = OP_BNE;  end
          2: begin f3 = 3'd4; s.e.op = OP_BLT;  end
          3: begin f3 = 3'd5; s.e.op = OP_BGE;  end
          4: begin f3 = 3'd6; s.e.op = OP_BLTU; end
          default: begin f3 = 3'd7; s.e.op = OP_BGEU; end
        endcase
        s.w = {v[12], v[10:5], rs2, rs1, f3, v[4:1], v[11], 7'b1100011};
        s.e.rs1 = rs1; s.e.rs2 = rs2; s.e.imm = v;
      end
      6: begin
        v = $urandom;
        s.e.op = v[0] ? OP_LUI : OP_AUIPC;
        s.w = {v[31:12], rd, v[0] ? 7'b0110111 : 7'b0010111};
        s.e.rd = rd; s.e.imm = {v[31:12], 12'd0};
      end
      7: begin
        v = (32'($urandom_range(0, 1048575)) - 32'd524288) * 2;
        s.e.op = OP_JAL;
        s.w = {v[20], v[10:1], v[11], v[19:12], rd, 7'b1101111};
        s.e.rd = rd; s.e.imm = v;
      end
      default: begin
        s.legal = 1'b0;
        s.e     = DEC_BUBBLE;
        v       = $urandom;
        case ($urandom_range(0, 7))
          0: s.w = 32'hFFFF_FFFF;
          1: s.w = {v[31:7], 7'b1110011};
          2: s.w = {7'b0000001, rs2, rs1, v[2:0], rd, 7'b0110011};
          3: s.w = {7'b0100000, rs2, rs1, 3'd1, rd, 7'b0010011};
          4: s.w = {7'b0110000, rs2, rs1, 3'd5, rd, 7'b0010011};
          5: s.w = {v[31:25], rs2, rs1, 3'd2, v[11:7], 7'b1100011};
          6: s.w = {7'b0100000, rs2, rs1, 3'd0, rd, 7'b0010011};
          default: s.w = {v[31:20], rs1, 3'd1, rd, 7'b1100111};
        endcase
      end
    endcase
    return s;
  endfunction

  function automatic stim_t mk(input logic [31:0] w, input op_t op, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [4:0] rd,
                               input logic [31:0] imm, input logic has_imm);
    stim_t s;
    s.w = w; s.legal = 1'b1;
    s.e = '{op: op, rs1: rs1, rs2: rs2, rd: rd, imm: imm, has_imm: has_imm};
    return s;
  endfunction

  initial begin
    stim_t idle, s_addi, s_sw, s_beq, s_lui, s_sub, s_bad;
    idle  = mk(32'd0, OP_NONE, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
    s_addi = mk(32'hFFB1_0093, OP_ADD, 5'd2, 5'd0, 5'd1, 32'hFFFF_FFFB, 1'b1);
    s_sw   = mk(32'h0051_2423, OP_SW,  5'd2, 5'd5, 5'd0, 32'd8, 1'b1);
    s_beq  = mk(32'hFE20_88E3, OP_BEQ, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFF0, 1'b1);
    s_lui  = mk(32'h1234_53B7, OP_LUI, 5'd0, 5'd0, 5'd7, 32'h1234_5000, 1'b1);
    s_sub  = mk(32'h4052_01B3, OP_SUB, 5'd4, 5'd5, 5'd3, 32'd0, 1'b0);
    s_bad.w = 32'hFFFF_FFFF; s_bad.legal = 1'b0; s_bad.e = DEC_BUBBLE;

    // Reset state, then addi x1,x2,-5 with two-edge latency and one-cycle issue.
    do_reset(1'b1, 32'hFFB1_0093);
    cycle(1'b1, s_addi, 1'b0, 1'b0);
    cycle(1'b0, idle,   1'b0, 1'b0);
    cycle(1'b0, idle,   1'b0, 1'b0);

    // sw/beq/lui back to back with iq_full held for 4 cycles.
    cycle(1'b1, s_sw,  1'b0, 1'b1);
    cycle(1'b1, s_beq, 1'b0, 1'b1);
    cycle(1'b1, s_lui, 1'b0, 1'b1);
    cycle(1'b1, s_lui, 1'b0, 1'b1);
    cycle(1'b1, s_lui, 1'b0, 1'b0);
    cycle(1'b1, s_lui, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, idle, 1'b0, 1'b0);

    // R-type sub.
    cycle(1'b1, s_sub, 1'b0, 1'b0);
    cycle(1'b0, idle,  1'b0, 1'b0);
    cycle(1'b0, idle,  1'b0, 1'b0);

    // Flush with a full buffer and a word offered, then with a word accepted.
    cycle(1'b1, gen(1'b0), 1'b0, 1'b1);
    cycle(1'b1, gen(1'b0), 1'b0, 1'b1);
    cycle(1'b1, gen(1'b0), 1'b1, 1'b0);
    cycle(1'b1, gen(1'b0), 1'b0, 1'b1);
    cycle(1'b1, gen(1'b0), 1'b1, 1'b1);
    cycle(1'b1, s_sub,     1'b0, 1'b0);
    cycle(1'b0, idle,      1'b0, 1'b0);
    cycle(1'b0, idle,      1'b0, 1'b0);

    // All-ones illegal word, then a legal word, then flush and resume.
    cycle(1'b1, s_bad,  1'b0, 1'b0);
    cycle(1'b1, s_addi, 1'b0, 1'b0);
    cycle(1'b0, idle,   1'b0, 1'b0);
    cycle(1'b0, idle,   1'b0, 1'b0);
    cycle(1'b0, idle,   1'b1, 1'b0);
    cycle(1'b1, s_beq,  1'b0, 1'b0);
    cycle(1'b0, idle,   1'b0, 1'b0);
    cycle(1'b0, idle,   1'b0, 1'b0);

    // Reset with the FIFO full: nothing buffered may appear afterwards.
    cycle(1'b1, gen(1'b0), 1'b0, 1'b1);
    cycle(1'b1, gen(1'b0), 1'b0, 1'b1);
    do_reset(1'b1, 32'hFFB1_0093);
    for (int i = 0; i < 3; i++) cycle(1'b0, idle, 1'b0, 1'b0);

    // Random traffic with occasional flushes, backpressure and illegal words.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), gen(1'b1),
            1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 2) == 0));
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, idle, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
